// File: rtl/id_stage_p.sv
// id_stage_p: parametrised decode stage feeding the ID/EX boundary.
// Decodes the instruction, sign-extends the immediate, reads two operands
// from an internal register file, and registers everything into the ID/EX
// slot. It handles load-use stalls with bubble insertion, branch flushes,
// and a hard-wired zero register.
// Optional: define ID_WB_BYPASS_EN to make the register-file read ports
// write-through, so a same-cycle write-back value is forwarded.
module id_stage_p #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr_in,
   input  logic [XLEN-1:0]   pc_in,
   input  logic              valid_in,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   output logic              stall_out,
   output logic              valid_out,
   output logic [31:0]       instr_out,
   output logic [XLEN-1:0]   pc_out,
   output logic [5:0]        opcode_out,
   output logic [XLEN-1:0]   imm_out,
   output logic [XLEN-1:0]   val_rs_out,
   output logic [XLEN-1:0]   val_rt_out,
   output logic [REG_AW-1:0] rwd_out
);

   // Opcode encodings shared with the rest of the pipeline (def.v values).
   localparam logic [5:0] OP_SDW  = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_LDW  = 6'b100011;
   localparam logic [5:0] OP_JUMP = 6'b000010;
   localparam int         NREG    = 1 << REG_AW;

   logic [XLEN-1:0]   rf_q [NREG];

   logic              valid_q;
   logic [31:0]       instr_q;
   logic [XLEN-1:0]   pc_q;
   logic [5:0]        opc_q;
   logic [XLEN-1:0]   imm_q;
   logic [XLEN-1:0]   rs_q;
   logic [XLEN-1:0]   rt_q;
   logic [REG_AW-1:0] rwd_q;

   logic [5:0]        opc_d;
   logic              is_mem_br;
   logic              no_dst;
   logic [REG_AW-1:0] src_a, src_b, dst_d;
   logic [XLEN-1:0]   imm_d;
   logic [XLEN-1:0]   rs_d, rt_d;
   logic              hz;
   logic              bubble;

   // Field decode: store/branch/load take operand B from the rt field.
   always_comb begin
      opc_d     = instr_in[31:26];
      is_mem_br = (opc_d == OP_SDW) || (opc_d == OP_BEQ) || (opc_d == OP_LDW);
      no_dst    = (opc_d == OP_SDW) || (opc_d == OP_BEQ) || (opc_d == OP_JUMP);
      src_a     = REG_AW'(instr_in[20:16]);
      src_b     = is_mem_br ? REG_AW'(instr_in[25:21]) : REG_AW'(instr_in[15:11]);
      dst_d     = no_dst ? '0 : REG_AW'(instr_in[25:21]);
      imm_d     = XLEN'($signed(instr_in[IMM_W-1:0]));
   end

   // Operand read; r0 is hard-wired to zero.
   always_comb begin
      rs_d = (src_a == '0) ? '0 : rf_q[src_a];
      rt_d = (src_b == '0) ? '0 : rf_q[src_b];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && (wb_addr != '0) && (wb_addr == src_a)) rs_d = wb_data;
      if (wb_en && (wb_addr != '0) && (wb_addr == src_b)) rt_d = wb_data;
`endif
   end

   // Load-use hazard against the load sitting in ID/EX; jumps read nothing.
   always_comb begin
      hz = valid_in && valid_q && (opc_q == OP_LDW) && (rwd_q != '0) &&
           ((rwd_q == src_a) || (rwd_q == src_b)) && (opc_d != OP_JUMP);
      bubble    = flush || hz || !valid_in;
      stall_out = hz && !flush;
   end

   // Register file write port; r0 writes are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // ID/EX boundary: a bubble zeroes the whole slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         opc_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rwd_q   <= '0;
      end else if (bubble) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         opc_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rwd_q   <= '0;
      end else begin
         valid_q <= 1'b1;
         instr_q <= instr_in;
         pc_q    <= pc_in;
         opc_q   <= opc_d;
         imm_q   <= imm_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rwd_q   <= dst_d;
      end
   end

   assign valid_out  = valid_q;
   assign instr_out  = instr_q;
   assign pc_out     = pc_q;
   assign opcode_out = opc_q;
   assign imm_out    = imm_q;
   assign val_rs_out = rs_q;
   assign val_rt_out = rt_q;
   assign rwd_out    = rwd_q;

endmodule
